// File: rtl/hd44780_responder.sv
// Device-side model of an HD44780U on an 8-bit LCD bus: decodes E/RS/RWB strobes,
// runs the instruction set against an internal DDRAM and answers BF/AC and data reads.
module hd44780_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int DDRAM_DEPTH = 80,
  parameter int BUSY_SHORT  = 4,
  parameter int BUSY_LONG   = 100
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  e_i,
  input  logic                  rs_i,
  input  logic                  rwb_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_oe_o,
  output logic                  busy_o,
  output logic [6:0]            ac_o,
  output logic                  display_on_o,
  output logic                  protocol_err_o,
  input  logic [6:0]            mem_raddr_i,
  output logic [7:0]            mem_rdata_o
);

  localparam int AW = 7;
  localparam int CW = $clog2(BUSY_LONG + 1);
  localparam logic [AW-1:0] LAST    = AW'(DDRAM_DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DDRAM_DEPTH);
  localparam logic [CW-1:0] CNT_SHORT = CW'(BUSY_SHORT);
  localparam logic [CW-1:0] CNT_LONG  = CW'(BUSY_LONG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_CLEARING
  } state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [AW-1:0]   ac_q, ac_n;
  logic [AW-1:0]   fill_q, fill_n;
  logic            inc_q, inc_n;
  logic            disp_q, disp_n;
  logic            err_q, err_n;
  logic            e_q, rs_q, rwb_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [7:0]      mem [0:DDRAM_DEPTH-1];
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [7:0]      mem_wd;

  logic            fall, bf_read, go_short, go_long;

  // Linear address counter step with wrap at both ends of the DDRAM.
  function automatic logic [AW-1:0] ac_step(input logic [AW-1:0] a, input logic up);
    if (up) return (a == LAST) ? '0 : a + 1'b1;
    else    return (a == '0) ? LAST : a - 1'b1;
  endfunction

  assign fall    = e_q & ~e_i;
  assign bf_read = ~rs_q & rwb_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n  = state_q;
    cnt_n    = cnt_q;
    ac_n     = ac_q;
    fill_n   = fill_q;
    inc_n    = inc_q;
    disp_n   = disp_q;
    err_n    = err_q;
    mem_we   = 1'b0;
    mem_wa   = ac_q;
    mem_wd   = data_i[7:0];
    go_short = 1'b0;
    go_long  = 1'b0;

    unique case (state_q)
      S_BUSY: begin
        cnt_n = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) state_n = S_IDLE;
      end
      S_CLEARING: begin
        mem_we = 1'b1;
        mem_wa = fill_q;
        mem_wd = 8'h20;
        fill_n = fill_q + 1'b1;
        cnt_n  = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        // The counter keeps running during the fill so a clear costs BUSY_LONG in total.
        if (fill_q == LAST) state_n = (cnt_q > CW'(1)) ? S_BUSY : S_IDLE;
      end
      default: ;
    endcase

    if (fall && !bf_read) begin
      if (state_q != S_IDLE) begin
        err_n = 1'b1;
      end else if (rs_q) begin
        if (!rwb_q) mem_we = 1'b1;
        ac_n     = ac_step(ac_q, inc_q);
        go_short = 1'b1;
      end else begin
        casez (data_i[7:0])
          8'b1???????: begin
            if ({1'b0, data_i[6:0]} >= DEPTH_W) begin
              ac_n  = '0;
              err_n = 1'b1;
            end else begin
              ac_n = data_i[6:0];
            end
            go_short = 1'b1;
          end
          8'b01??????, 8'b001?????: go_short = 1'b1;
          8'b0001????: begin
            if (!data_i[3]) ac_n = ac_step(ac_q, data_i[2]);
            go_short = 1'b1;
          end
          8'b00001???: begin
            disp_n   = data_i[2];
            go_short = 1'b1;
          end
          8'b000001??: begin
            inc_n    = data_i[1];
            go_short = 1'b1;
          end
          8'b0000001?: begin
            ac_n    = '0;
            go_long = 1'b1;
          end
          8'b00000001: begin
            state_n = S_CLEARING;
            cnt_n   = CNT_LONG;
            fill_n  = '0;
            ac_n    = '0;
            inc_n   = 1'b1;
          end
          default: ;
        endcase
      end
    end

    if (go_short) begin
      state_n = S_BUSY;
      cnt_n   = CNT_SHORT;
    end else if (go_long) begin
      state_n = S_BUSY;
      cnt_n   = CNT_LONG;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= S_CLEARING;
      cnt_q   <= CNT_LONG;
      ac_q    <= '0;
      fill_q  <= '0;
      inc_q   <= 1'b1;
      disp_q  <= 1'b0;
      err_q   <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      rwb_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ac_q    <= ac_n;
      fill_q  <= fill_n;
      inc_q   <= inc_n;
      disp_q  <= disp_n;
      err_q   <= err_n;
      e_q     <= e_i;
      rs_q    <= rs_i;
      rwb_q   <= rwb_i;
      // rs_i is used directly so the read value is ready one cycle after E rises.
      data_q  <= rs_i ? DATA_WIDTH'(mem[ac_q]) : DATA_WIDTH'({busy_o, ac_q});
    end
  end

  // NOTE: the DDRAM has no reset; its contents are defined by the clearing fill.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) mem[mem_wa] <= mem_wd;
  end

  assign busy_o         = (state_q != S_IDLE);
  assign data_o         = data_q;
  assign data_oe_o      = e_q & rwb_q;
  assign ac_o           = ac_q;
  assign display_on_o   = disp_q;
  assign protocol_err_o = err_q;
  assign mem_rdata_o    = ({1'b0, mem_raddr_i} < DEPTH_W) ? mem[mem_raddr_i] : 8'h00;

endmodule

// File: tb/tb_hd44780_responder.sv
// Directed bench for hd44780_responder: bus tasks push expected read data into a
// scoreboard queue that a monitor drains whenever the responder drives DB.
module tb_hd44780_responder;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       e_i = 1'b0, rs_i = 1'b0, rwb_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       data_oe_o, busy_o, display_on_o, protocol_err_o;
  logic [6:0] ac_o;
  logic [6:0] mem_raddr_i = 7'd0;
  logic [7:0] mem_rdata_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [7:0] value;
  } exp_t;
  exp_t exp_q[$];

  hd44780_responder #(
    .DATA_WIDTH(8), .DDRAM_DEPTH(80), .BUSY_SHORT(4), .BUSY_LONG(100)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .e_i(e_i), .rs_i(rs_i), .rwb_i(rwb_i),
    .data_i(data_i), .data_o(data_o), .data_oe_o(data_oe_o), .busy_o(busy_o),
    .ac_o(ac_o), .display_on_o(display_on_o), .protocol_err_o(protocol_err_o),
    .mem_raddr_i(mem_raddr_i), .mem_rdata_o(mem_rdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    rs_i = rs; rwb_i = 1'b0; data_i = d; e_i = 1'b1;
    cyc(); cyc();
    e_i = 1'b0;
    cyc();
  endtask

  task automatic bus_read(input logic rs, input logic [7:0] exp, input string name);
    exp_q.push_back('{name, exp});
    rs_i = rs; rwb_i = 1'b1; e_i = 1'b1;
    cyc();
    check({name, "_oe_latency"}, data_oe_o, 1);
    cyc();
    e_i = 1'b0;
    cyc();
    rwb_i = 1'b0;
  endtask

  // Counts busy cycles from the current sample point; a stuck BF is a failure.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o !== 1'b0 && n < 400) begin
      n++;
      cyc();
    end
    check("idle_timeout", busy_o, 0);
  endtask

  task automatic mem_chk(input logic [6:0] addr, input logic [7:0] exp, input string name);
    mem_raddr_i = addr;
    #1;
    check(name, mem_rdata_o, exp);
  endtask

  // Scoreboard monitor: compares the first driven cycle of every read.
  logic oe_seen = 1'b0;
  always @(posedge clk_i) begin
    #1;
    if (data_oe_o === 1'b1 && !oe_seen) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got 0x%0h expected no read", data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, data_o, e.value);
      end
    end
    oe_seen = (data_oe_o === 1'b1);
  end

  initial begin
    int n;

    // 1. reset state and fill
    cyc(); cyc(); cyc();
    check("rst_data_o", data_o, 8'h00);
    check("rst_oe", data_oe_o, 0);
    check("rst_ac", ac_o, 0);
    check("rst_busy", busy_o, 1);
    check("rst_disp", display_on_o, 0);
    check("rst_err", protocol_err_o, 0);
    rst_i = 1'b0;
    wait_idle(n);
    check("reset_busy_cycles", n, 100);
    mem_chk(7'd0, 8'h20, "fill_0");
    mem_chk(7'd40, 8'h20, "fill_40");
    mem_chk(7'd79, 8'h20, "fill_79");
    mem_chk(7'd100, 8'h00, "raddr_out_of_range");
    bus_read(1'b0, 8'h00, "bf_after_reset");

    // 2. addressed write
    bus_write(1'b0, 8'h85);
    check("set_addr_ac", ac_o, 5);
    wait_idle(n);
    check("short_busy_cycles", n, 4);
    bus_write(1'b1, 8'h41);
    bus_read(1'b0, 8'h86, "bf_during_busy");
    mem_chk(7'd5, 8'h41, "mem5_write");
    check("ac_after_write", ac_o, 6);
    wait_idle(n);

    // 3. decrement wrap
    bus_write(1'b0, 8'h04); wait_idle(n);
    bus_write(1'b0, 8'h80); wait_idle(n);
    bus_write(1'b1, 8'h42);
    mem_chk(7'd0, 8'h42, "mem0_write");
    check("ac_dec_wrap", ac_o, 79);
    wait_idle(n);
    bus_write(1'b0, 8'h06); wait_idle(n);

    // 4. write while busy
    bus_write(1'b0, 8'h86);
    bus_write(1'b1, 8'h55);
    mem_chk(7'd6, 8'h20, "mem6_unchanged");
    check("ac_busy_write", ac_o, 6);
    check("err_set", protocol_err_o, 1);
    wait_idle(n);
    bus_read(1'b0, 8'h06, "bf_after_err");
    check("err_sticky", protocol_err_o, 1);

    // 5. display control, data read, clear
    bus_write(1'b0, 8'h0C);
    check("display_on", display_on_o, 1);
    wait_idle(n);
    bus_write(1'b0, 8'h85); wait_idle(n);
    bus_read(1'b1, 8'h41, "data_read_mem5");
    check("ac_after_read", ac_o, 6);
    wait_idle(n);
    check("read_busy_cycles", n, 4);
    bus_write(1'b0, 8'h01);
    check("clear_ac", ac_o, 0);
    wait_idle(n);
    check("clear_busy_cycles", n, 100);
    mem_chk(7'd0, 8'h20, "clear_0");
    mem_chk(7'd5, 8'h20, "clear_5");
    mem_chk(7'd79, 8'h20, "clear_79");
    check("err_after_clear", protocol_err_o, 1);
    bus_write(1'b0, 8'h85); wait_idle(n);
    bus_write(1'b0, 8'hD0);
    check("bad_addr_ac", ac_o, 0);
    wait_idle(n);

    // 6. reset mid-clear
    bus_write(1'b0, 8'hB2); wait_idle(n);
    bus_write(1'b1, 8'h33); wait_idle(n);
    bus_write(1'b0, 8'h01);
    repeat (29) cyc();
    mem_chk(7'd50, 8'h33, "mid_clear_mem50");
    rst_i = 1'b1;
    cyc(); cyc();
    check("rst2_busy", busy_o, 1);
    check("rst2_ac", ac_o, 0);
    check("rst2_disp", display_on_o, 0);
    check("rst2_err", protocol_err_o, 0);
    check("rst2_oe", data_oe_o, 0);
    rst_i = 1'b0;
    wait_idle(n);
    check("rst2_busy_cycles", n, 100);
    mem_chk(7'd50, 8'h20, "refill_50");
    mem_chk(7'd0, 8'h20, "refill_0");
    mem_chk(7'd79, 8'h20, "refill_79");

    cyc();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
